// File: rtl/seq_mult16_cla.sv
// Sequential 16x16 unsigned shift-add multiplier. Every partial-product addition
// goes through one shared 16-bit carry-lookahead adder, one addition per cycle.

module sixteen_bit_CLA (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Four 4-bit lookahead groups; each exports a group generate/propagate pair.
    for (genvar k = 0; k < 4; k++) begin : g_grp
        logic [3:0] gk;
        logic [3:0] pk;
        logic       ci;

        assign gk = g[4*k +: 4];
        assign pk = p[4*k +: 4];
        assign ci = gc[k];

        assign c[4*k]     = ci;
        assign c[4*k + 1] = gk[0] | (pk[0] & ci);
        assign c[4*k + 2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & ci);
        assign c[4*k + 3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                          | (pk[2] & pk[1] & pk[0] & ci);

        assign gg[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                     | (pk[3] & pk[2] & pk[1] & gk[0]);
        assign gp[k] = &pk;
    end

    // Second-level lookahead across the groups.
    assign gc[0] = cin_i;
    assign gc[1] = gg[0] | (gp[0] & cin_i);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin_i);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

    assign sum_o  = p ^ c;
    assign cout_o = gc[4];
endmodule

module seq_mult16_cla (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [1:0]  state_o
);
    localparam int N_ITER = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] mcand_q;
    logic [15:0] acc_hi_q;
    logic [15:0] acc_lo_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] product_q;

    logic [15:0] addend;
    logic [15:0] sum;
    logic        cout;
    logic [31:0] acc_d;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = acc_lo_q[0] ? mcand_q : 16'h0000;

    sixteen_bit_CLA u_cla (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .cin_i (1'b0),
        .sum_o (sum),
        .cout_o(cout)
    );

    // The carry-out becomes the new accumulator MSB, so no carry is ever dropped.
    assign acc_d = {cout, sum, acc_lo_q[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= 16'h0000;
            acc_hi_q  <= 16'h0000;
            acc_lo_q  <= 16'h0000;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a;
                        acc_hi_q <= 16'h0000;
                        acc_lo_q <= b;
                        cnt_q    <= 4'd0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    {acc_hi_q, acc_lo_q} <= acc_d;
                    cnt_q                <= cnt_q + 4'd1;
                    if (cnt_q == 4'(N_ITER - 1)) begin
                        product_q <= acc_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_seq_mult16_cla.sv
// Self-checking bench for seq_mult16_cla: directed scenarios plus a long
// randomized back-to-back run checked against plain a*b arithmetic.

module tb_seq_mult16_cla;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [1:0]  state_o;

    int n_checks;
    int n_fail;

    logic [31:0] exp_q[$];

    seq_mult16_cla dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xx;
        logic [31:0] yy;
        xx = {16'h0000, x};
        yy = {16'h0000, y};
        return xx * yy;
    endfunction

    // Driver: one start pulse, then watch 40 cycles for busy/done behaviour.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         output logic [31:0] prod, output int lat,
                         output int busy_cnt, output int done_cnt);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        lat = -1;
        prod = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i;
                    prod = product;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, want 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b, want 0", done);
        end
        n_checks++;
        if (product !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_product: got %h, want 00000000", product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] prod;
        int lat, bc, dc;
        do_op(16'd3, 16'd5, prod, lat, bc, dc);
        n_checks++;
        if (prod !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL basic_product: got %h, want 0000000f", prod);
        end
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want 16", lat);
        end
        n_checks++;
        if (bc !== 16) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++;
            $display("FAIL basic_done_pulses: got %0d, want 1", dc);
        end
        n_checks++;
        if (product !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL basic_product_held: got %h, want 0000000f", product);
        end
    endtask

    task automatic test_corners();
        logic [15:0] ta[4];
        logic [15:0] tb[4];
        logic [31:0] prod;
        int lat, bc, dc;
        ta[0] = 16'hFFFF; tb[0] = 16'hFFFF;
        ta[1] = 16'h1234; tb[1] = 16'h0000;
        ta[2] = 16'h0000; tb[2] = 16'hBEEF;
        ta[3] = 16'h8001; tb[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], prod, lat, bc, dc);
            n_checks++;
            if (prod !== ref_mul(ta[i], tb[i])) begin
                n_fail++;
                $display("FAIL corner_product[%0d]: got %h, want %h", i, prod, ref_mul(ta[i], tb[i]));
            end
            n_checks++;
            if (lat !== 16 || dc !== 1) begin
                n_fail++;
                $display("FAIL corner_timing[%0d]: got lat=%0d pulses=%0d, want lat=16 pulses=1", i, lat, dc);
            end
        end
    endtask

    task automatic test_start_ignored();
        int seen;
        @(negedge clk);
        a = 16'd7;
        b = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 16'd2;
        b = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_checks++;
        if (seen !== 1 || product !== 32'h0000_003F) begin
            n_fail++;
            $display("FAIL ignore_product: got done=%0d product=%h, want done=1 product=0000003f", seen, product);
        end
        // Hold start through DONE; the accept must wait for IDLE.
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_accept_in_done: got busy=%b done=%b, want 0 0", busy, done);
        end
        a = 16'd3;
        b = 16'd5;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_reaccept: got busy=%b, want 1", busy);
        end
        start = 1'b0;
        a = 16'hAAAA;
        b = 16'h5555;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_checks++;
        if (seen !== 1 || product !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL ignore_reaccept_product: got done=%0d product=%h, want done=1 product=0000000f", seen, product);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] prod;
        int lat, bc, dc;
        int pulses;
        @(negedge clk);
        a = 16'h00FF;
        b = 16'h0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || product !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got busy=%b product=%h, want 0 00000000", busy, product);
        end
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || product !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got pulses=%0d product=%h, want 0 00000000", pulses, product);
        end
        do_op(16'h00FF, 16'h0100, prod, lat, bc, dc);
        n_checks++;
        if (prod !== 32'h0000_FF00 || lat !== 16) begin
            n_fail++;
            $display("FAIL midreset_restart: got product=%h lat=%0d, want 0000ff00 16", prod, lat);
        end
    endtask

    task automatic test_back_to_back(input int n_ops);
        int issued, completed, cycle, last_done, spacing_bad, prod_bad;
        logic [15:0] ra, rb;
        logic [31:0] exp;
        issued = 0;
        completed = 0;
        cycle = 0;
        last_done = -1;
        spacing_bad = 0;
        prod_bad = 0;
        exp_q.delete();
        @(negedge clk);
        ra = 16'($urandom());
        rb = 16'($urandom());
        a = ra;
        b = rb;
        start = 1'b1;
        exp_q.push_back(ref_mul(ra, rb));
        issued++;
        while (completed < n_ops && cycle < n_ops * 18 + 100) begin
            @(negedge clk);
            cycle++;
            if (done) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                if (product !== exp) begin
                    prod_bad++;
                    if (prod_bad <= 5)
                        $display("FAIL b2b_product[%0d]: got %h, want %h", completed, product, exp);
                end
                if (last_done >= 0 && cycle - last_done != 18) begin
                    spacing_bad++;
                    if (spacing_bad <= 5)
                        $display("FAIL b2b_spacing[%0d]: got %0d, want 18", completed, cycle - last_done);
                end
                last_done = cycle;
                completed++;
                // Next edge returns to IDLE; new operands go in before the accepting edge.
                @(negedge clk);
                cycle++;
                if (issued < n_ops) begin
                    ra = 16'($urandom());
                    rb = 16'($urandom());
                    if (issued % 250 == 1) begin
                        ra = 16'hFFFF;
                        rb = 16'hFFFF;
                    end
                    a = ra;
                    b = rb;
                    exp_q.push_back(ref_mul(ra, rb));
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (completed !== n_ops) begin
            n_fail++;
            $display("FAIL b2b_completed: got %0d, want %0d", completed, n_ops);
        end
        n_checks++;
        if (prod_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_products: got %0d wrong, want 0", prod_bad);
        end
        n_checks++;
        if (spacing_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: got %0d irregular, want 0", spacing_bad);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_corners();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back(1000);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
